// File: rtl/key_operand_collector.sv
// Key-entry front end for the calculator: turns ASCII key strobes into two
// packed-BCD operands, digit counts and an operator, then pulses calc_start on '='.
module key_operand_collector #(
    parameter int DIGITS = 4,
    parameter int DW     = 4 * DIGITS,
    parameter int CW     = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_valid,
    input  logic [7:0]    key_code,
    output logic [DW-1:0] reg_num1,
    output logic [DW-1:0] reg_num2,
    output logic [CW-1:0] cnt1,
    output logic [CW-1:0] cnt2,
    output logic [7:0]    sym,
    output logic          calc_start,
    output logic          busy,
    output logic          ovf
);

    typedef enum logic [2:0] {NUM1, OPR, NUM2, ISSUE, HOLD} state_t;

    localparam logic [CW-1:0] MAX_CNT = CW'(DIGITS);

    state_t     state;
    logic       is_digit;
    logic       is_op;
    logic       is_eq;
    logic       is_clr;
    logic [3:0] digit;

    assign digit    = key_code[3:0];
    assign is_digit = (key_code[7:4] == 4'h3) && (key_code[3:0] <= 4'd9);
    assign is_op    = (key_code >= 8'h61) && (key_code <= 8'h64);
    assign is_eq    = (key_code == 8'h3D);
    assign is_clr   = (key_code == 8'h1B);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= NUM1;
            reg_num1   <= '0;
            reg_num2   <= '0;
            cnt1       <= '0;
            cnt2       <= '0;
            sym        <= '0;
            calc_start <= 1'b0;
            busy       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            calc_start <= 1'b0;
            // ISSUE lasts one cycle; any key seen in it is handled as in HOLD
            if (state == ISSUE)
                state <= HOLD;
            if (key_valid) begin
                if (is_clr) begin
                    state    <= NUM1;
                    reg_num1 <= '0;
                    reg_num2 <= '0;
                    cnt1     <= '0;
                    cnt2     <= '0;
                    sym      <= '0;
                    busy     <= 1'b0;
                    ovf      <= 1'b0;
                end else begin
                    case (state)
                        NUM1: begin
                            if (is_digit) begin
                                if (cnt1 < MAX_CNT) begin
                                    reg_num1 <= {reg_num1[DW-5:0], digit};
                                    cnt1     <= cnt1 + 1'b1;
                                end else begin
                                    ovf <= 1'b1;
                                end
                            end else if (is_op && (cnt1 != '0)) begin
                                sym   <= key_code;
                                state <= OPR;
                            end
                        end
                        OPR: begin
                            if (is_op) begin
                                sym <= key_code;
                            end else if (is_digit) begin
                                reg_num2 <= {{(DW-4){1'b0}}, digit};
                                cnt2     <= {{(CW-1){1'b0}}, 1'b1};
                                state    <= NUM2;
                            end
                        end
                        NUM2: begin
                            if (is_digit) begin
                                if (cnt2 < MAX_CNT) begin
                                    reg_num2 <= {reg_num2[DW-5:0], digit};
                                    cnt2     <= cnt2 + 1'b1;
                                end else begin
                                    ovf <= 1'b1;
                                end
                            end else if (is_eq) begin
                                calc_start <= 1'b1;
                                busy       <= 1'b1;
                                state      <= ISSUE;
                            end
                        end
                        ISSUE, HOLD: begin
                            if (is_digit) begin
                                reg_num1 <= {{(DW-4){1'b0}}, digit};
                                cnt1     <= {{(CW-1){1'b0}}, 1'b1};
                                reg_num2 <= '0;
                                cnt2     <= '0;
                                sym      <= '0;
                                busy     <= 1'b0;
                                ovf      <= 1'b0;
                                state    <= NUM1;
                            end
                        end
                        default: state <= NUM1;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_key_operand_collector.sv
// Directed + random key streams checked against a value-level model of the collector.
module tb_key_operand_collector;

    localparam int DIGITS = 4;
    localparam int DW     = 4 * DIGITS;
    localparam int CW     = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          key_valid = 1'b0;
    logic [7:0]    key_code = 8'h00;
    logic [DW-1:0] reg_num1;
    logic [DW-1:0] reg_num2;
    logic [CW-1:0] cnt1;
    logic [CW-1:0] cnt2;
    logic [7:0]    sym;
    logic          calc_start;
    logic          busy;
    logic          ovf;

    key_operand_collector #(.DIGITS(DIGITS), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .reg_num1(reg_num1), .reg_num2(reg_num2), .cnt1(cnt1), .cnt2(cnt2),
        .sym(sym), .calc_start(calc_start), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: operands kept as decimal integers, phase 0=first operand,
    // 1=operator chosen, 2=second operand, 3=result pending (busy)
    int         m_phase;
    int         m_v1, m_v2, m_c1, m_c2;
    logic [7:0] m_sym;
    bit         m_busy, m_ovf, m_start;

    function automatic logic [DW-1:0] to_bcd(input int v);
        logic [DW-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_v1 = 0; m_v2 = 0; m_c1 = 0; m_c2 = 0;
        m_sym = 8'h00; m_busy = 0; m_ovf = 0; m_start = 0;
    endtask

    task automatic model_key(input bit v, input logic [7:0] c);
        int d;
        m_start = 0;
        if (!v) return;
        d = int'(c) - 48;
        if (c == 8'h1B) begin
            model_reset();
        end else if (c >= 8'h30 && c <= 8'h39) begin
            case (m_phase)
                0: if (m_c1 < DIGITS) begin m_v1 = m_v1 * 10 + d; m_c1++; end else m_ovf = 1;
                1: begin m_v2 = d; m_c2 = 1; m_phase = 2; end
                2: if (m_c2 < DIGITS) begin m_v2 = m_v2 * 10 + d; m_c2++; end else m_ovf = 1;
                default: begin
                    model_reset();
                    m_v1 = d; m_c1 = 1;
                end
            endcase
        end else if (c >= 8'h61 && c <= 8'h64) begin
            if ((m_phase == 0 && m_c1 > 0) || m_phase == 1) begin
                m_sym = c; m_phase = 1;
            end
        end else if (c == 8'h3D && m_phase == 2) begin
            m_phase = 3; m_busy = 1; m_start = 1;
        end
    endtask

    task automatic check(input string tag);
        assert (reg_num1 === to_bcd(m_v1)) else begin miscompares++;
            $error("FAIL %s reg_num1 observed=%h expected=%h", tag, reg_num1, to_bcd(m_v1)); end
        assert (reg_num2 === to_bcd(m_v2)) else begin miscompares++;
            $error("FAIL %s reg_num2 observed=%h expected=%h", tag, reg_num2, to_bcd(m_v2)); end
        assert (cnt1 === CW'(m_c1)) else begin miscompares++;
            $error("FAIL %s cnt1 observed=%0d expected=%0d", tag, cnt1, m_c1); end
        assert (cnt2 === CW'(m_c2)) else begin miscompares++;
            $error("FAIL %s cnt2 observed=%0d expected=%0d", tag, cnt2, m_c2); end
        assert (sym === m_sym) else begin miscompares++;
            $error("FAIL %s sym observed=%h expected=%h", tag, sym, m_sym); end
        assert (calc_start === m_start) else begin miscompares++;
            $error("FAIL %s calc_start observed=%b expected=%b", tag, calc_start, m_start); end
        assert (busy === m_busy) else begin miscompares++;
            $error("FAIL %s busy observed=%b expected=%b", tag, busy, m_busy); end
        assert (ovf === m_ovf) else begin miscompares++;
            $error("FAIL %s ovf observed=%b expected=%b", tag, ovf, m_ovf); end
    endtask

    // One clock per call; key_valid is left as driven so consecutive calls give
    // back-to-back strobes.
    task automatic apply(input bit v, input logic [7:0] c, input string tag);
        @(negedge clk);
        key_valid = v;
        key_code  = c;
        @(posedge clk);
        #1;
        model_key(v, c);
        vectors++;
        $display("step %0d %s valid=%b key=%h n1=%h c1=%0d n2=%h c2=%0d sym=%h start=%b busy=%b ovf=%b",
                 vectors, tag, v, c, reg_num1, cnt1, reg_num2, cnt2, sym, calc_start, busy, ovf);
        check(tag);
    endtask

    task automatic keys(input string s, input string tag);
        for (int i = 0; i < s.len(); i++)
            apply(1'b1, s[i], tag);
        apply(1'b0, 8'h00, tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        key_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        vectors++;
        check(tag);
    endtask

    initial begin
        int r;
        logic [7:0] c;
        model_reset();

        do_reset("reset");

        keys("12a345=", "seq_add");
        assert (calc_start === 1'b0 && reg_num1 === 16'h0012 && reg_num2 === 16'h0345 && busy === 1'b1)
            else begin miscompares++;
                $error("FAIL seq_add_final observed n1=%h n2=%h start=%b busy=%b expected 0012 0345 0 1",
                       reg_num1, reg_num2, calc_start, busy); end

        keys("a=", "hold_ignore");
        keys("6", "leave_hold");
        assert (reg_num1 === 16'h0006 && cnt1 === 3'd1 && sym === 8'h00 && ovf === 1'b0)
            else begin miscompares++;
                $error("FAIL leave_hold_final observed n1=%h c1=%0d sym=%h ovf=%b expected 0006 1 00 0",
                       reg_num1, cnt1, sym, ovf); end

        keys({8'h1B}, "clear");
        keys("12345b9=", "seq_ovf");
        assert (reg_num1 === 16'h1234 && ovf === 1'b1 && sym === 8'h62 && reg_num2 === 16'h0009)
            else begin miscompares++;
                $error("FAIL seq_ovf_final observed n1=%h ovf=%b sym=%h n2=%h expected 1234 1 62 0009",
                       reg_num1, ovf, sym, reg_num2); end

        keys({8'h1B}, "clear");
        keys("a=7a=c2=", "seq_opr");
        assert (sym === 8'h63 && reg_num1 === 16'h0007 && reg_num2 === 16'h0002)
            else begin miscompares++;
                $error("FAIL seq_opr_final observed sym=%h n1=%h n2=%h expected 63 0007 0002",
                       sym, reg_num1, reg_num2); end

        keys({8'h1B}, "clear");
        keys("9d3=5", "back2back");
        keys({8'h1B, "77b12", 8'h1B, "4"}, "clear_num2");

        // Asynchronous reset landing in ISSUE
        keys({8'h1B, "8c1"}, "pre_issue");
        apply(1'b1, "=", "issue");
        key_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        vectors++;
        check("rst_in_issue");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        check("after_rst");
        keys("3", "post_rst_digit");

        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 45)       c = 8'h30 + 8'($urandom_range(0, 9));
            else if (r < 60)  c = 8'h61 + 8'($urandom_range(0, 3));
            else if (r < 70)  c = 8'h3D;
            else if (r < 73)  c = 8'h1B;
            else if (r < 82)  begin
                case ($urandom_range(0, 3))
                    0: c = 8'h2F;
                    1: c = 8'h3A;
                    2: c = 8'h60;
                    default: c = 8'h65;
                endcase
            end else          c = 8'h00;
            apply(r < 82, c, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/key_operand_collector.md
Name: key_operand_collector

Overview:
- Upstream stage of the calculator arithmetic block.
- Consumes one-cycle keypad/UART key strobes as ASCII codes and assembles two packed-BCD operands, their digit counts, and the operator code.
- Issues a one-cycle start pulse when '=' is entered.
- Outputs feed the arithmetic block's reg_num1, reg_num2, cnt1, cnt2 and sym inputs directly.

Parameters:
DIGITS, 4, max decimal digits per operand
DW, 4*DIGITS, packed-BCD operand width (derived, do not override)
CW, 3, digit-count width; must hold the value DIGITS

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
key_valid  input  1  one-cycle strobe, key_code valid
key_code  input  8  ASCII key: '0'-'9'=0x30-0x39, ops 0x61-0x64, '='=0x3D, clear=0x1B
reg_num1  output  DW  operand 1, packed BCD, nibble 0 = units digit
reg_num2  output  DW  operand 2, packed BCD, nibble 0 = units digit
cnt1  output  CW  digits held in reg_num1 (0..DIGITS)
cnt2  output  CW  digits held in reg_num2 (0..DIGITS)
sym  output  8  operator code 0x61 add, 0x62 sub, 0x63 mul, 0x64 div
calc_start  output  1  one-cycle pulse: operands and sym valid
busy  output  1  high from '=' acceptance until next key accepted in HOLD
ovf  output  1  sticky: a digit was dropped because the operand was full

Behaviour:
- Reset (async, rst=1): all outputs 0; state NUM1.
- A key is sampled only on a clk edge with key_valid=1. Keys arriving every cycle must all be accepted. Codes outside the set above are ignored, with no state change.
- Digit entry:
  - Shift in as {reg[DW-5:0], d}; cnt += 1.
  - Applies only when cnt < DIGITS.
  - When cnt == DIGITS the digit is dropped and ovf is set. Register and cnt are unchanged.
- States:
  - NUM1: digit → update reg_num1/cnt1. Op key with cnt1>0 → sym=code, go OPR. Op key with cnt1==0 is ignored. '=' is ignored.
  - OPR: op key → overwrite sym, stay. Digit → load reg_num2/cnt2 with that first digit, go NUM2. '=' is ignored.
  - NUM2: digit → update reg_num2/cnt2. Op key is ignored. '=' → go ISSUE.
  - ISSUE (1 cycle): calc_start=1, busy=1; go HOLD. Keys accepted in ISSUE are treated as in HOLD.
  - HOLD: outputs frozen, busy=1.
    - Digit → clear everything, load that digit as the first digit of reg_num1 (cnt1=1), busy=0, go NUM1.
    - Op key and '=' are ignored.
- Latency: calc_start is high in the cycle immediately after the edge that accepts '='.
- Operand stability: reg_num1, reg_num2, cnt1, cnt2 and sym do not change from the start pulse until a key leaves HOLD.
- Clear key (0x1B), any state: registers, counts, sym, ovf and busy → 0; state NUM1; calc_start is not asserted. Clear has priority over everything except rst.
- ovf clears only on clear, rst, or leaving HOLD.
- No division-by-zero check here; the arithmetic block owns that.
- rst asserted mid-entry or during ISSUE: immediate return to reset values; a pending calc_start is suppressed.

Test Plan:
- Keys '1','2','a','3','4','5','=' → reg_num1=0x0012, cnt1=2, sym=0x61, reg_num2=0x0345, cnt2=3; exactly one calc_start pulse one cycle after '='; busy=1.
- Keys '1','2','3','4','5' → reg_num1=0x1234, cnt1=4, ovf=1; then 'b','9','=' → sym=0x62, reg_num2=0x0009, calc_start pulses.
- Keys '7','a','c','2','=' → sym=0x63 (operator overwritten in OPR); '=' before any num2 digit, or 'a' as the first key, has no effect.
- After a completed calc: key '6' → reg_num2=0, cnt2=0, sym=0, reg_num1=0x0006, cnt1=1, busy=0, ovf=0. Keys 'a' and '=' in HOLD → no change, no second pulse.
- Back-to-back key_valid on consecutive cycles '9','d','3','=' → all accepted: reg_num1=0x9, sym=0x64, reg_num2=0x3, pulse.
- Clear mid-NUM2, and rst asserted asynchronously in ISSUE → all outputs 0, no calc_start, next digit starts reg_num1.
